// File: rtl/icache_refill_monitor_if.sv
// Refill channel bundle between the I-cache and its memory port.
// The master drives the request/response signals; the monitor observes them through the slave modport.
interface icache_refill_monitor_if #(
   parameter int CHANNELS = 2,
   parameter int ADDR_W   = 32
);
   logic [CHANNELS-1:0]        req_valid;
   logic [CHANNELS-1:0]        req_ready;
   logic [CHANNELS*ADDR_W-1:0] req_addr;
   logic [CHANNELS-1:0]        resp_valid;
   logic [CHANNELS-1:0]        resp_last;

   modport master (
      output req_valid,
      output req_ready,
      output req_addr,
      output resp_valid,
      output resp_last
   );

   modport slave (
      input  req_valid,
      input  req_ready,
      input  req_addr,
      input  resp_valid,
      input  resp_last
   );
endinterface

// File: rtl/icache_refill_monitor.sv
// I-cache refill protocol monitor: per-channel outstanding/beat tracking, sticky first-error capture.
// Optional per-channel watchdog (code 5) is built only when ICACHE_REFILL_MON_TIMEOUT_EN is defined.
module icache_refill_monitor #(
   parameter int CHANNELS        = 2,
   parameter int ADDR_W          = 32,
   parameter int BEATS           = 4,
   parameter int BEAT_BYTES      = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT         = 1024
) (
   input  logic                    clock,
   input  logic                    reset_n,
   icache_refill_monitor_if.slave  refill,
   input  logic                    err_clear,
   output logic                    err_valid,
   output logic [2:0]              err_code,
   output logic [2:0]              err_channel,
   output logic [15:0]             err_count,
   output logic [CHANNELS*4-1:0]   outstanding
);

   localparam int BLK_LSB = $clog2(BEATS * BEAT_BYTES);
   localparam int BEAT_W  = $clog2(BEATS);
   localparam logic [3:0]        MAX_OS    = 4'(MAX_OUTSTANDING);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
      $error("icache_refill_monitor: CHANNELS must be 1..8");
   end
   if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
      $error("icache_refill_monitor: BEATS must be a power of 2, >= 2");
   end
   if (BEAT_BYTES < 1 || (BEAT_BYTES & (BEAT_BYTES - 1)) != 0) begin : g_bad_beat_bytes
      $error("icache_refill_monitor: BEAT_BYTES must be a power of 2");
   end
   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_os
      $error("icache_refill_monitor: MAX_OUTSTANDING must be 1..15");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("icache_refill_monitor: TIMEOUT must be >= 2");
   end

   logic [BEAT_W-1:0] beat_cnt [CHANNELS];

   logic [CHANNELS-1:0] req_fire;
   logic [CHANNELS-1:0] resp_done;
   logic [CHANNELS-1:0] v_resp_no_req;
   logic [CHANNELS-1:0] v_overflow;
   logic [CHANNELS-1:0] v_misalign;
   logic [CHANNELS-1:0] v_last_mis;
   logic [CHANNELS-1:0] v_timeout;
   logic [CHANNELS-1:0] ch_viol;
   logic [2:0]          cap_code;
   logic [2:0]          cap_chan;

   // Only the block-offset bits of the address are checked.
   logic unused_addr_bits;
   assign unused_addr_bits = ^refill.req_addr;

   always_comb begin
      req_fire      = '0;
      resp_done     = '0;
      v_resp_no_req = '0;
      v_overflow    = '0;
      v_misalign    = '0;
      v_last_mis    = '0;
      ch_viol       = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         req_fire[c]      = refill.req_valid[c] & refill.req_ready[c];
         resp_done[c]     = refill.resp_valid[c] & refill.resp_last[c];
         v_resp_no_req[c] = refill.resp_valid[c] & (outstanding[c*4 +: 4] == 4'd0) & ~req_fire[c];
         v_overflow[c]    = req_fire[c] & (outstanding[c*4 +: 4] == MAX_OS) & ~resp_done[c];
         v_misalign[c]    = req_fire[c] & (refill.req_addr[c*ADDR_W +: BLK_LSB] != '0);
         v_last_mis[c]    = refill.resp_valid[c] & (refill.resp_last[c] != (beat_cnt[c] == LAST_BEAT));
         ch_viol[c]       = v_resp_no_req[c] | v_overflow[c] | v_misalign[c] | v_last_mis[c] | v_timeout[c];
      end
   end

   // Walk from the top channel down so the lowest violating channel wins.
   always_comb begin
      cap_code = 3'd0;
      cap_chan = 3'd0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (ch_viol[c]) begin
            cap_chan = 3'(c);
            if (v_resp_no_req[c])   cap_code = 3'd1;
            else if (v_overflow[c]) cap_code = 3'd2;
            else if (v_misalign[c]) cap_code = 3'd3;
            else if (v_last_mis[c]) cap_code = 3'd4;
            else                    cap_code = 3'd5;
         end
      end
   end

`ifdef ICACHE_REFILL_MON_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0]     wd_cnt [CHANNELS];
   logic [CHANNELS-1:0] wd_fired;

   always_comb begin
      v_timeout = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         v_timeout[c] = (wd_cnt[c] == WD_MAX) & ~wd_fired[c];
      end
   end

   // Watchdog saturates at TIMEOUT-1 and flags once until the channel makes progress.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wd_fired <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            wd_cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (refill.resp_valid[c] || (outstanding[c*4 +: 4] == 4'd0)) begin
               wd_cnt[c]   <= '0;
               wd_fired[c] <= 1'b0;
            end else begin
               if (wd_cnt[c] != WD_MAX) wd_cnt[c] <= wd_cnt[c] + 1'b1;
               if (v_timeout[c])        wd_fired[c] <= 1'b1;
            end
         end
      end
   end
`else
   assign v_timeout = '0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         outstanding <= '0;
         err_valid   <= 1'b0;
         err_code    <= 3'd0;
         err_channel <= 3'd0;
         err_count   <= 16'd0;
         for (int c = 0; c < CHANNELS; c++) begin
            beat_cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            // Overflowing requests and orphan completions leave the count untouched.
            if ((req_fire[c] & ~v_overflow[c]) && !(resp_done[c] & ~v_resp_no_req[c])) begin
               outstanding[c*4 +: 4] <= outstanding[c*4 +: 4] + 4'd1;
            end else if (!(req_fire[c] & ~v_overflow[c]) && (resp_done[c] & ~v_resp_no_req[c])) begin
               outstanding[c*4 +: 4] <= outstanding[c*4 +: 4] - 4'd1;
            end
            // A last beat always realigns the beat counter; otherwise it wraps naturally.
            if (refill.resp_valid[c]) begin
               beat_cnt[c] <= refill.resp_last[c] ? '0 : beat_cnt[c] + 1'b1;
            end
         end

         if ((|ch_viol) && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
         end

         if ((|ch_viol) && (!err_valid || err_clear)) begin
            err_valid   <= 1'b1;
            err_code    <= cap_code;
            err_channel <= cap_chan;
         end else if (err_clear) begin
            err_valid   <= 1'b0;
            err_code    <= 3'd0;
            err_channel <= 3'd0;
         end
      end
   end

endmodule

// File: tb/tb_icache_refill_monitor.sv
// Directed bench for icache_refill_monitor (2 channels, 4 beats of 8 bytes, 4 outstanding, TIMEOUT=16).
module tb_icache_refill_monitor;
   localparam int CH = 2;
   localparam int AW = 32;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        err_clear = 1'b0;
   logic        err_valid;
   logic [2:0]  err_code;
   logic [2:0]  err_channel;
   logic [15:0] err_count;
   logic [CH*4-1:0] outstanding;

   int n_tests = 0;
   int n_fail  = 0;

   icache_refill_monitor_if #(.CHANNELS(CH), .ADDR_W(AW)) bus ();

   icache_refill_monitor #(
      .CHANNELS(CH), .ADDR_W(AW), .BEATS(4), .BEAT_BYTES(8),
      .MAX_OUTSTANDING(4), .TIMEOUT(16)
   ) u_dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .refill      (bus),
      .err_clear   (err_clear),
      .err_valid   (err_valid),
      .err_code    (err_code),
      .err_channel (err_channel),
      .err_count   (err_count),
      .outstanding (outstanding)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.req_valid  = '0;
      bus.req_ready  = '0;
      bus.req_addr   = '0;
      bus.resp_valid = '0;
      bus.resp_last  = '0;
      err_clear      = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic req(input int c, input logic [31:0] addr);
      bus.req_valid[c]        = 1'b1;
      bus.req_ready[c]        = 1'b1;
      bus.req_addr[c*AW +: AW] = addr;
   endtask

   task automatic beat(input int c, input logic last);
      bus.resp_valid[c] = 1'b1;
      bus.resp_last[c]  = last;
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_valid", 32'(err_valid), 32'd0);
      chk("rst_code",  32'(err_code), 32'd0);
      chk("rst_chan",  32'(err_channel), 32'd0);
      chk("rst_count", 32'(err_count), 32'd0);
      chk("rst_os",    32'(outstanding), 32'h00);
      reset_n = 1'b1;

      // legal refill on ch0
      req(0, 32'h8000_0040);
      cyc();
      chk("legal_os_req", 32'(outstanding), 32'h01);
      for (int i = 0; i < 4; i++) begin
         beat(0, i == 3);
         cyc();
         if (i == 2) chk("legal_os_mid", 32'(outstanding), 32'h01);
      end
      chk("legal_os_done", 32'(outstanding), 32'h00);
      chk("legal_valid",   32'(err_valid), 32'd0);
      chk("legal_count",   32'(err_count), 32'd0);

      // response with nothing outstanding on ch1
      beat(1, 1'b0);
      cyc();
      chk("noreq_valid", 32'(err_valid), 32'd1);
      chk("noreq_code",  32'(err_code), 32'd1);
      chk("noreq_chan",  32'(err_channel), 32'd1);
      chk("noreq_count", 32'(err_count), 32'd1);
      chk("noreq_os",    32'(outstanding), 32'h00);

      err_clear = 1'b1;
      cyc();
      chk("clr_valid", 32'(err_valid), 32'd0);
      chk("clr_code",  32'(err_code), 32'd0);
      chk("clr_count", 32'(err_count), 32'd1);

      // ch0 last-mismatch and ch1 misalign in the same cycle
      req(0, 32'h0000_2000);
      cyc();
      chk("pri_os_pre", 32'(outstanding), 32'h01);
      beat(0, 1'b1);
      req(1, 32'h0000_2004);
      cyc();
      chk("pri_valid", 32'(err_valid), 32'd1);
      chk("pri_chan",  32'(err_channel), 32'd0);
      chk("pri_code",  32'(err_code), 32'd4);
      chk("pri_count", 32'(err_count), 32'd2);
      chk("pri_os",    32'(outstanding), 32'h10);
      // ch1 beat counter sits at 1 after the orphan beat; finish its refill legally
      beat(1, 1'b0); cyc();
      beat(1, 1'b0); cyc();
      beat(1, 1'b1); cyc();
      chk("ch1_drain_os",    32'(outstanding), 32'h00);
      chk("ch1_drain_count", 32'(err_count), 32'd2);

      // overflow on the fifth request
      err_clear = 1'b1;
      cyc();
      chk("ovf_clr_valid", 32'(err_valid), 32'd0);
      for (int i = 0; i < 5; i++) begin
         req(0, 32'h0000_3000 + 32'(i * 32));
         cyc();
         if (i == 3) begin
            chk("ovf_os_full",  32'(outstanding), 32'h04);
            chk("ovf_no_err",   32'(err_valid), 32'd0);
         end
      end
      chk("ovf_valid", 32'(err_valid), 32'd1);
      chk("ovf_code",  32'(err_code), 32'd2);
      chk("ovf_chan",  32'(err_channel), 32'd0);
      chk("ovf_count", 32'(err_count), 32'd3);
      chk("ovf_os",    32'(outstanding), 32'h04);
      for (int i = 0; i < 16; i++) begin
         beat(0, (i % 4) == 3);
         cyc();
      end
      chk("ovf_drain_os",    32'(outstanding), 32'h00);
      chk("ovf_drain_count", 32'(err_count), 32'd3);

      // clear loses against a new misalign
      err_clear = 1'b1;
      req(0, 32'h0000_1008);
      cyc();
      chk("clrmis_valid", 32'(err_valid), 32'd1);
      chk("clrmis_code",  32'(err_code), 32'd3);
      chk("clrmis_chan",  32'(err_channel), 32'd0);
      chk("clrmis_count", 32'(err_count), 32'd4);
      chk("clrmis_os",    32'(outstanding), 32'h01);
      for (int i = 0; i < 4; i++) begin
         beat(0, i == 3);
         cyc();
      end
      chk("clrmis_drain_os", 32'(outstanding), 32'h00);

      err_clear = 1'b1;
      cyc();
      chk("wd_clr_valid", 32'(err_valid), 32'd0);
      req(0, 32'h0000_4000);
      cyc();
`ifdef ICACHE_REFILL_MON_TIMEOUT_EN
      repeat (15) cyc();
      chk("wd_pre_valid", 32'(err_valid), 32'd0);
      chk("wd_pre_count", 32'(err_count), 32'd4);
      cyc();
      chk("wd_valid", 32'(err_valid), 32'd1);
      chk("wd_code",  32'(err_code), 32'd5);
      chk("wd_chan",  32'(err_channel), 32'd0);
      chk("wd_count", 32'(err_count), 32'd5);
      repeat (20) cyc();
      chk("wd_once_count", 32'(err_count), 32'd5);
      beat(0, 1'b0);
      cyc();
      repeat (15) cyc();
      chk("wd_restart_pre", 32'(err_count), 32'd5);
      cyc();
      chk("wd_restart_hit", 32'(err_count), 32'd6);
`else
      repeat (100) cyc();
      chk("nowd_valid", 32'(err_valid), 32'd0);
      chk("nowd_count", 32'(err_count), 32'd4);
      chk("nowd_os",    32'(outstanding), 32'h01);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
